// File: rtl/pwm_mc_if.sv
// Sample/control and PWM output bundle for the multi-channel PWM stage.
// The sample source drives through master; the PWM core sits on slave.
interface pwm_mc_if #(
  parameter int N  = 8,
  parameter int CH = 2
);
  logic            en;
  logic            center;
  logic [CH*N-1:0] din;
  logic            din_valid;
  logic [CH-1:0]   pwmout;
  logic            frame;
  logic            upd_pending;

  modport master (
    output en, center, din, din_valid,
    input  pwmout, frame, upd_pending
  );

  modport slave (
    input  en, center, din, din_valid,
    output pwmout, frame, upd_pending
  );
endinterface

// File: rtl/pwm_mc.sv
// Multi-channel PWM DAC: CH signed samples compared against one shared ramp,
// edge- or centre-aligned, with duty and mode changes applied at period starts.
module pwm_mc #(
  parameter int N  = 8,
  parameter int CH = 2
) (
  input  logic     clk,
  input  logic     areset,
  pwm_mc_if.slave  bus
);

  localparam logic [N-1:0] MID_CODE = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};
  localparam logic [N-1:0] ONE_N    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N:0]   ONE_N1   = {{N{1'b0}}, 1'b1};

  logic [N-1:0]  cnt_r;
  logic [N-1:0]  cnt_nxt_s;
  logic          ph_r;
  logic          ph_nxt_s;
  logic          mode_r;
  logic          mode_nxt_s;
  logic          pend_r;
  logic          pend_nxt_s;
  logic [CH-1:0] pwm_r;
  logic [CH-1:0] pwm_nxt_s;
  logic          frame_r;
  logic          frame_nxt_s;
  logic [N-1:0]  shadow_r   [CH];
  logic [N-1:0]  shadow_nxt_s [CH];
  logic [N-1:0]  active_r   [CH];
  logic [N-1:0]  active_nxt_s [CH];
  logic [N-1:0]  duty_s     [CH];
  logic [N-1:0]  ramp_s;
  logic          wrap_s;
  logic          load_s;

  // Offset-binary duty codes, ramp value and period-wrap detection.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      duty_s[c] = bus.din[c*N +: N] ^ MID_CODE;
    end
    ramp_s = ph_r ? ~cnt_r : cnt_r;
    wrap_s = (cnt_r == ALL_ONES) && (ph_r || !mode_r);
    // Holding en low keeps the stage sitting on a permanent period boundary.
    load_s = !bus.en || wrap_s;
  end

  // Next-state logic for counter, duty buffers, mode and registered outputs.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    ph_nxt_s    = ph_r;
    mode_nxt_s  = mode_r;
    pend_nxt_s  = pend_r;
    pwm_nxt_s   = {CH{1'b0}};
    frame_nxt_s = 1'b0;
    for (int c = 0; c < CH; c++) begin
      shadow_nxt_s[c] = shadow_r[c];
      active_nxt_s[c] = active_r[c];
    end

    if (load_s) begin
      cnt_nxt_s  = {N{1'b0}};
      ph_nxt_s   = 1'b0;
      mode_nxt_s = bus.center;
      pend_nxt_s = 1'b0;
      for (int c = 0; c < CH; c++) begin
        if (bus.din_valid) begin
          shadow_nxt_s[c] = duty_s[c];
          active_nxt_s[c] = duty_s[c];
        end else begin
          active_nxt_s[c] = shadow_r[c];
        end
      end
    end else begin
      if (mode_r) begin
        {ph_nxt_s, cnt_nxt_s} = {ph_r, cnt_r} + ONE_N1;
      end else begin
        cnt_nxt_s = cnt_r + ONE_N;
        ph_nxt_s  = 1'b0;
      end
      if (bus.din_valid) begin
        pend_nxt_s = 1'b1;
        for (int c = 0; c < CH; c++) begin
          shadow_nxt_s[c] = duty_s[c];
        end
      end else begin
        pend_nxt_s = pend_r;
      end
    end

    if (bus.en) begin
      frame_nxt_s = (cnt_r == {N{1'b0}}) && !ph_r;
      for (int c = 0; c < CH; c++) begin
        pwm_nxt_s[c] = (ramp_s < active_r[c]);
      end
    end else begin
      frame_nxt_s = 1'b0;
      pwm_nxt_s   = {CH{1'b0}};
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!areset) begin
      cnt_r   <= {N{1'b0}};
      ph_r    <= 1'b0;
      mode_r  <= 1'b0;
      pend_r  <= 1'b0;
      pwm_r   <= {CH{1'b0}};
      frame_r <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        shadow_r[c] <= MID_CODE;
        active_r[c] <= MID_CODE;
      end
    end else begin
      cnt_r   <= cnt_nxt_s;
      ph_r    <= ph_nxt_s;
      mode_r  <= mode_nxt_s;
      pend_r  <= pend_nxt_s;
      pwm_r   <= pwm_nxt_s;
      frame_r <= frame_nxt_s;
      for (int c = 0; c < CH; c++) begin
        shadow_r[c] <= shadow_nxt_s[c];
        active_r[c] <= active_nxt_s[c];
      end
    end
  end

  assign bus.pwmout      = pwm_r;
  assign bus.frame       = frame_r;
  assign bus.upd_pending = pend_r;

endmodule

// File: tb/tb_pwm_mc.sv
// Directed bench for pwm_mc (N=8, CH=2): period lengths, high times, update
// timing around boundaries, enable gating and mid-pulse reset.
module tb_pwm_mc;

  logic clk;
  logic areset;

  pwm_mc_if #(.N(8), .CH(2)) bus ();

  pwm_mc #(.N(8), .CH(2)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   hi0, hi1, nfr, ffr, npend, nasym;
  logic s0 [512];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Samples len output cycles starting now; optionally pulses din_valid at
  // positions p1/p2 so the capture edge is the one ending that cycle.
  task automatic run(input int len, input int p1, input logic [15:0] v1,
                     input int p2, input logic [15:0] v2);
    hi0 = 0; hi1 = 0; nfr = 0; ffr = -1; npend = 0;
    for (int i = 0; i < len; i++) begin
      if (bus.pwmout[0] === 1'b1) hi0++;
      if (bus.pwmout[1] === 1'b1) hi1++;
      if (i < 512) s0[i] = bus.pwmout[0];
      if (bus.frame === 1'b1) begin
        nfr++;
        if (ffr < 0) ffr = i;
      end
      if (bus.upd_pending === 1'b1) npend++;
      if (i == p1) begin
        bus.din = v1; bus.din_valid = 1'b1;
      end else if (i == p2) begin
        bus.din = v2; bus.din_valid = 1'b1;
      end else begin
        bus.din_valid = 1'b0;
      end
      tick();
    end
    bus.din_valid = 1'b0;
  endtask

  initial begin
    areset = 1'b0;
    bus.en = 1'b0;
    bus.center = 1'b0;
    bus.din = 16'h0000;
    bus.din_valid = 1'b0;

    // Reset: everything low
    repeat (3) tick();
    check("rst_pwm", {30'd0, bus.pwmout}, 32'd0);
    check("rst_frame", {31'd0, bus.frame}, 32'd0);
    check("rst_pend", {31'd0, bus.upd_pending}, 32'd0);

    // First period after release: frame and pwm one cycle after first edge
    areset = 1'b1;
    bus.en = 1'b1;
    tick();
    check("first_frame", {31'd0, bus.frame}, 32'd1);
    check("first_pwm", {30'd0, bus.pwmout}, 32'd3);
    run(256, -1, 16'h0, -1, 16'h0);
    check("e1_hi0", hi0, 32'd128);
    check("e1_hi1", hi1, 32'd128);
    check("e1_nfr", nfr, 32'd1);
    check("e1_ffr", ffr, 32'd0);
    check("e1_pend", npend, 32'd0);
    check("e1_next_frame", {31'd0, bus.frame}, 32'd1);

    // Mid-period update: current period unchanged, pending 101..254
    run(256, 100, 16'h7F80, -1, 16'h0);
    check("e2_hi0", hi0, 32'd128);
    check("e2_hi1", hi1, 32'd128);
    check("e2_pend", npend, 32'd154);
    check("e2_pend_at_frame", {31'd0, bus.upd_pending}, 32'd0);
    run(256, -1, 16'h0, -1, 16'h0);
    check("e3_hi0", hi0, 32'd0);
    check("e3_hi1", hi1, 32'd255);
    check("e3_nfr", nfr, 32'd1);
    check("e3_pend", npend, 32'd0);

    // Centre request mid-period: this period stays edge-aligned
    bus.center = 1'b1;
    run(256, 10, 16'h7F40, -1, 16'h0);
    check("e4_hi0", hi0, 32'd0);
    check("e4_hi1", hi1, 32'd255);
    check("e4_pend", npend, 32'd244);
    run(512, -1, 16'h0, -1, 16'h0);
    check("c1_hi0", hi0, 32'd384);
    check("c1_hi1", hi1, 32'd510);
    check("c1_nfr", nfr, 32'd1);
    check("c1_ffr", ffr, 32'd0);
    nasym = 0;
    for (int i = 0; i < 256; i++) begin
      if (s0[i] !== s0[511-i]) nasym++;
    end
    check("c1_symmetric", nasym, 32'd0);
    check("c1_s0_0", {31'd0, s0[0]}, 32'd1);
    check("c1_s0_191", {31'd0, s0[191]}, 32'd1);
    check("c1_s0_192", {31'd0, s0[192]}, 32'd0);
    check("c1_s0_256", {31'd0, s0[256]}, 32'd0);

    // Capture on the boundary edge: write-through, no pending
    run(512, 510, 16'h00C0, -1, 16'h0);
    check("c2_hi0", hi0, 32'd384);
    check("c2_hi1", hi1, 32'd510);
    check("c2_pend", npend, 32'd0);
    // Boundary-1 capture (pending one cycle), then boundary+1 capture
    run(512, 509, 16'h0000, 511, 16'h4020);
    check("c3_hi0", hi0, 32'd128);
    check("c3_hi1", hi1, 32'd256);
    check("c3_pend", npend, 32'd1);
    // Second capture in the same period overrides the boundary+1 one
    run(512, 100, 16'hE060, -1, 16'h0);
    check("c4_hi0", hi0, 32'd256);
    check("c4_hi1", hi1, 32'd256);
    check("c4_pend", npend, 32'd511);
    run(512, -1, 16'h0, -1, 16'h0);
    check("c5_hi0", hi0, 32'd448);
    check("c5_hi1", hi1, 32'd192);
    check("c5_nfr", nfr, 32'd1);

    // en low for 10 cycles mid-period with a fresh sample and edge mode
    run(200, -1, 16'h0, -1, 16'h0);
    bus.en = 1'b0;
    bus.center = 1'b0;
    bus.din = 16'h7F80;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.din_valid = 1'b0;
      check("en_low_out", {29'd0, bus.frame, bus.pwmout}, 32'd0);
    end
    check("en_low_pend", {31'd0, bus.upd_pending}, 32'd0);
    bus.en = 1'b1;
    tick();
    check("reen_frame", {31'd0, bus.frame}, 32'd1);
    run(256, -1, 16'h0, -1, 16'h0);
    check("reen_hi0", hi0, 32'd0);
    check("reen_hi1", hi1, 32'd255);
    check("reen_nfr", nfr, 32'd1);
    check("reen_next_frame", {31'd0, bus.frame}, 32'd1);

    // Reset during a high pulse, then replay the first scenario
    run(50, -1, 16'h0, -1, 16'h0);
    check("pre_rst_hi", {31'd0, bus.pwmout[1]}, 32'd1);
    areset = 1'b0;
    tick();
    check("mid_rst_out", {28'd0, bus.upd_pending, bus.frame, bus.pwmout}, 32'd0);
    tick();
    areset = 1'b1;
    tick();
    check("rr_frame", {31'd0, bus.frame}, 32'd1);
    check("rr_pwm", {30'd0, bus.pwmout}, 32'd3);
    run(256, -1, 16'h0, -1, 16'h0);
    check("rr_hi0", hi0, 32'd128);
    check("rr_hi1", hi1, 32'd128);
    check("rr_nfr", nfr, 32'd1);
    check("rr_next_frame", {31'd0, bus.frame}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
